// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end for the decode stage.
// Issues word fetches to instruction memory and buffers the returned words in
// an in-order FIFO. Decode receives one {inst, pc} per cycle over valid/ready.
// A redirect flushes the FIFO and drops stale responses that are still in flight.
// Optional feature: define IFU_FETCH_ERR_EN to add bus-error capture
// (i_imem_err, o_inst_err) and a HALT state that stops fetching until the next redirect.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_en,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
`ifdef IFU_FETCH_ERR_EN
    input  logic        i_imem_err,
    output logic        o_inst_err,
`endif
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_vld,
    input  logic        i_inst_rdy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
`ifdef IFU_FETCH_ERR_EN
        , HALT
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
`ifdef IFU_FETCH_ERR_EN
        logic        err;
`endif
    } entry_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      redir_tgt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_nxt;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   credit_used;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    entry_t           mem [FIFO_DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic             fire;
    logic             push;
    logic             pop;
    logic             resp_err;

    // Masking (rather than slicing) keeps every redirect bit in use; the low two bits drop out.
    assign redir_tgt = i_redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_FETCH_ERR_EN
    assign resp_err = i_imem_err;
`else
    assign resp_err = 1'b0;
`endif

    // Buffered entries plus requests in flight never exceed the FIFO size,
    // so every response has a slot waiting for it.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign o_imem_req  = (state == FETCH) && !i_redirect && (credit_used < {1'b0, CNT_FULL});
    assign o_imem_addr = fetch_pc;
    assign fire        = o_imem_req && i_imem_gnt;

    // Responses are kept only in FETCH and outside a redirect cycle. Anything else is stale.
    assign push = i_imem_rvalid && (state == FETCH) && !i_redirect;
    assign pop  = o_inst_vld && i_inst_rdy;

    assign head       = mem[rd_ptr];
    assign o_inst_vld = (fifo_cnt != '0);
    assign o_inst     = o_inst_vld ? head.inst : NOP;
    assign o_inst_pc  = o_inst_vld ? head.pc   : 32'h0;
`ifdef IFU_FETCH_ERR_EN
    assign o_inst_err = o_inst_vld && head.err;
`endif

    // Next outstanding count: a grant adds one; every response (kept or discarded) removes one.
    always_comb begin
        out_nxt = outstanding;
        if (fire)          out_nxt = out_nxt + CNT_ONE;
        if (i_imem_rvalid) out_nxt = out_nxt - CNT_ONE;
    end

    // Build the FIFO entry. A faulted response is replaced by a NOP.
    always_comb begin
        wr_entry      = '0;
        wr_entry.inst = resp_err ? NOP : i_imem_rdata;
        wr_entry.pc   = resp_pc;
`ifdef IFU_FETCH_ERR_EN
        wr_entry.err  = resp_err;
`endif
    end

    // Control FSM, fetch/response PC tracking and the outstanding counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= out_nxt;
            if (fire) fetch_pc <= fetch_pc + 32'd4;
            if (push) resp_pc  <= resp_pc + 32'd4;
            if (i_redirect) begin
                fetch_pc <= redir_tgt;
                resp_pc  <= redir_tgt;
            end
            case (state)
                IDLE:  if (i_fetch_en) state <= FETCH;
                FETCH: begin
                    if (i_redirect) state <= (out_nxt != '0) ? DRAIN : FETCH;
`ifdef IFU_FETCH_ERR_EN
                    else if (push && resp_err) state <= HALT;
`endif
                end
                DRAIN: if (!i_redirect && out_nxt == '0) state <= FETCH;
`ifdef IFU_FETCH_ERR_EN
                HALT:  if (i_redirect) state <= (out_nxt != '0) ? DRAIN : FETCH;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy. A redirect empties the buffer at the end of the cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (i_redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // FIFO storage. It needs no reset because o_inst_vld masks unwritten slots.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Protocol invariants: no orphan responses, no overflow, and credit stays bounded.
    a_rvalid_has_req: assert property (@(posedge i_clk) disable iff (!i_reset)
        i_imem_rvalid |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        push |-> (fifo_cnt != CNT_FULL || pop));
    a_out_bound: assert property (@(posedge i_clk) disable iff (!i_reset)
        outstanding <= CNT_FULL);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a per-cycle vector table covers streaming,
// back-pressure and redirects. Hand sequences cover credit limiting, mid-run reset,
// PC wrap and (with IFU_FETCH_ERR_EN) the error halt.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, redirect, gnt, rvalid, rdy, imem_err;
    logic [31:0] redirect_pc, rdata;
    logic        req, vld;
    logic [31:0] addr, inst, inst_pc;
`ifdef IFU_FETCH_ERR_EN
    logic        inst_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_fetch_en    (fetch_en),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
`ifdef IFU_FETCH_ERR_EN
        .i_imem_err    (imem_err),
        .o_inst_err    (inst_err),
`endif
        .o_inst        (inst),
        .o_inst_pc     (inst_pc),
        .o_inst_vld    (vld),
        .i_inst_rdy    (rdy)
    );

    typedef struct {
        logic        en, redir;
        logic [31:0] rpc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] inst, ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // The expected instruction is derived from the expected PC; an empty head shows NOP at PC 0.
    function automatic vec_t mk(input logic en, redir, input logic [31:0] rpc,
                                input logic g, rv, input logic [31:0] rd, input logic r,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] pc);
        vec_t t;
        t.en = en; t.redir = redir; t.rpc = rpc; t.gnt = g; t.rv = rv; t.rdata = rd;
        t.rdy = r; t.req = q; t.addr = a; t.vld = v;
        t.inst = v ? dat(pc) : NOP;
        t.ipc  = v ? pc : 32'h0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, redir, input logic [31:0] rpc,
                         input logic g, rv, input logic [31:0] rd, input logic r);
        @(negedge clk);
        fetch_en = en; redirect = redir; redirect_pc = rpc;
        gnt = g; rvalid = rv; rdata = rd; rdy = r;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 0; redirect = 0; redirect_pc = 0; gnt = 0;
        rvalid = 0; rdata = 0; rdy = 0; imem_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        pend;
        logic [31:0] pend_addr, exp_pc;
        int          grants, pops;

        // ---- vector table ----
        //               en rd rpc          g rv rdata             rdy| req addr         vld pc
        vecs.push_back(mk(0, 0, 0,           0, 0, 0,                0, 0, 32'h0,       0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 0, 32'h0,       0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 1, 32'h0,       0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h0),       1, 1, 32'h4,       0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h4),       1, 1, 32'h8,       1, 32'h0));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h8),       1, 1, 32'hC,       1, 32'h4));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'hC),       0, 1, 32'h10,      1, 32'h8));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h10),      0, 1, 32'h14,      1, 32'h8));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h14),      0, 0, 32'h18,      1, 32'h8));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                0, 0, 32'h18,      1, 32'h8));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 0, 32'h18,      1, 32'h8));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 1, 32'h18,      1, 32'hC));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h18),      1, 1, 32'h1C,      1, 32'h10));
        vecs.push_back(mk(1, 0, 0,           0, 1, dat(32'h1C),      1, 1, 32'h20,      1, 32'h14));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                0, 1, 32'h20,      1, 32'h18));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                0, 1, 32'h24,      1, 32'h18));
        vecs.push_back(mk(1, 1, 32'h102,     1, 0, 0,                1, 0, 32'h28,      1, 32'h18));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h20),      1, 0, 32'h100,     0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h24),      1, 0, 32'h100,     0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 1, 32'h100,     0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 1, dat(32'h100),     1, 1, 32'h104,     0, 0));
        vecs.push_back(mk(1, 0, 0,           0, 0, 0,                0, 1, 32'h108,     1, 32'h100));
        vecs.push_back(mk(1, 1, 32'h200,     1, 1, 32'hDEAD_BEEF,    1, 0, 32'h108,     1, 32'h100));
        vecs.push_back(mk(1, 0, 0,           0, 0, 0,                1, 1, 32'h200,     0, 0));
        vecs.push_back(mk(1, 0, 0,           1, 0, 0,                1, 1, 32'h200,     0, 0));
        vecs.push_back(mk(1, 0, 0,           0, 1, dat(32'h200),     1, 1, 32'h204,     0, 0));
        vecs.push_back(mk(1, 0, 0,           0, 0, 0,                1, 1, 32'h204,     1, 32'h200));
        vecs.push_back(mk(1, 0, 0,           0, 0, 0,                0, 1, 32'h204,     0, 0));

        // ---- reset values ----
        do_reset();
        #1;
        chk("reset req",  32'(req), 32'h0);
        chk("reset addr", addr,     32'h0);
        chk("reset vld",  32'(vld), 32'h0);
        chk("reset inst", inst,     NOP);
        chk("reset pc",   inst_pc,  32'h0);
`ifdef IFU_FETCH_ERR_EN
        chk("reset err",  32'(inst_err), 32'h0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].redir, vecs[i].rpc, vecs[i].gnt,
                  vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
            chk($sformatf("row%0d req", i),  32'(req), 32'(vecs[i].req));
            chk($sformatf("row%0d addr", i), addr,     vecs[i].addr);
            chk($sformatf("row%0d vld", i),  32'(vld), 32'(vecs[i].vld));
            chk($sformatf("row%0d inst", i), inst,     vecs[i].inst);
            chk($sformatf("row%0d pc", i),   inst_pc,  vecs[i].ipc);
        end

        // ---- credit limit from reset: rdy low, one-cycle memory ----
        do_reset();
        pend = 0; pend_addr = 0; grants = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 0, 1, pend, pend ? dat(pend_addr) : 32'h0, 0);
            if (req && gnt) begin grants++; pend = 1; pend_addr = addr; end
            else pend = 0;
        end
        chk("bp grants", 32'(grants), 32'd4);
        chk("bp req",    32'(req),    32'h0);
        chk("bp head",   inst,        dat(32'h0));

        // Release back-pressure: one pop per cycle in order, and requests resume.
        exp_pc = 0; pops = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 0, 0, 1, pend, pend ? dat(pend_addr) : 32'h0, 1);
            if (vld) begin
                chk("bp pop pc",   inst_pc, exp_pc);
                chk("bp pop inst", inst,    dat(exp_pc));
                exp_pc += 4; pops++;
            end
            if (req && gnt) begin grants++; pend = 1; pend_addr = addr; end
            else pend = 0;
        end
        chk("bp pops",   32'(pops),   32'd12);
        chk("bp resume", 32'(grants), 32'd15);

        // ---- reset mid-operation clears everything asynchronously ----
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 0, 1, pend, pend ? dat(pend_addr) : 32'h0, 0);
            if (req && gnt) begin pend = 1; pend_addr = addr; end
            else pend = 0;
        end
        chk("pre-rst vld", 32'(vld), 32'h1);
        @(negedge clk);
        #2; rst_n = 1'b0; rvalid = 0; gnt = 0;
        #1;
        chk("async rst vld",  32'(vld), 32'h0);
        chk("async rst req",  32'(req), 32'h0);
        chk("async rst inst", inst,     NOP);
        chk("async rst pc",   inst_pc,  32'h0);

        // ---- redirect in IDLE with low bits set, then fetch_pc wrap ----
        do_reset();
        drive(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        chk("idle redir req", 32'(req), 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("idle redir addr", addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("wrap req",  32'(req), 32'h1);
        chk("wrap addr0", addr,    32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 1, 32'h1234_5678, 0);
        chk("wrap addr1", addr, 32'h0000_0000);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wrap vld",  32'(vld), 32'h1);
        chk("wrap pc",   inst_pc,  32'hFFFF_FFFC);
        chk("wrap inst", inst,     32'h1234_5678);

`ifdef IFU_FETCH_ERR_EN
        // ---- error on the second response halts fetch until a redirect ----
        do_reset();
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("err addr0", addr, 32'h0);
        drive(1, 0, 0, 1, 1, dat(32'h0), 0);
        chk("err addr4", addr, 32'h4);
        imem_err = 1;
        drive(1, 0, 0, 1, 1, dat(32'h4), 0);
        chk("err addr8", addr, 32'h8);
        chk("err head0", 32'(inst_err), 32'h0);
        imem_err = 0;
        drive(1, 0, 0, 1, 1, dat(32'h8), 1);
        chk("halt req", 32'(req), 32'h0);
        chk("halt pc0", inst_pc,  32'h0);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("err vld",  32'(vld),      32'h1);
        chk("err inst", inst,          NOP);
        chk("err pc",   inst_pc,       32'h4);
        chk("err flag", 32'(inst_err), 32'h1);
        chk("halt req2", 32'(req),     32'h0);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("halt req3", 32'(req), 32'h0);
        drive(1, 1, 32'h40, 1, 0, 0, 1);
        drive(1, 0, 0, 1, 0, 0, 1);
        chk("resume req",  32'(req), 32'h1);
        chk("resume addr", addr,     32'h40);
        chk("resume err",  32'(inst_err), 32'h0);
        drive(1, 0, 0, 0, 1, dat(32'h40), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("resume pc",   inst_pc,       32'h40);
        chk("resume inst", inst,          dat(32'h40));
        chk("resume flag", 32'(inst_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
